// File: rtl/mimo_pkg.sv
// Shared types and constants for the MIMO detector H/Y streaming path.
// Holds the driver state enum, default sizes and the complex sample type.
package mimo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    STREAM,
    WAIT_DONE,
    FINISH
  } state_t;

  localparam int N_DEF     = 16;
  localparam int H_ELEMS   = 16;
  localparam int Y_LEN_DEF = 8;
  localparam int NUM_Q_DEF = 16;

  typedef struct packed {
    logic [N_DEF-1:0] r;
    logic [N_DEF-1:0] i;
  } cplx_t;

  function automatic logic addr_ok(
    input logic [4:0] a,
    input int         depth
  );
    return int'(a) < depth;
  endfunction

endpackage

// File: rtl/cplx_sample_buf.sv
// Register file of complex samples: synchronous write, asynchronous read.
// Contents are deliberately not reset so loaded data survives a run abort.
module cplx_sample_buf
  import mimo_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  cplx_t         wdata,
  input  logic [AW-1:0] raddr,
  output cplx_t         rdata
);

  cplx_t mem [DEPTH];

  // store one sample per write strobe
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hy_stream_driver.sv
// Transmit side of the H/Y stream into x_calculate: NUM_Q passes per go.
// Optional q_done watchdog is enabled by defining HY_DRV_WATCHDOG_EN.
module hy_stream_driver
  import mimo_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int Y_LEN   = Y_LEN_DEF,
  parameter int NUM_Q   = NUM_Q_DEF,
  parameter int TIMEOUT = 4096
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         wr_sel,
  input  logic [4:0]   wr_addr,
  input  logic [N-1:0] wr_data_r,
  input  logic [N-1:0] wr_data_i,
  input  logic         go,
  output logic         busy,
  output logic         all_done,
  output logic         err,
  output logic         start_new_q,
  output logic [3:0]   q_index,
  output logic         H_in_valid,
  output logic [N-1:0] H_in_r,
  output logic [N-1:0] H_in_i,
  output logic         Y_in_valid,
  output logic [N-1:0] Y_in_r,
  output logic [N-1:0] Y_in_i,
  input  logic         q_done
);

  localparam int HD  = ROWS * COLS;
  localparam int HAW = $clog2(HD);
  localparam int YAW = $clog2(Y_LEN);

  state_t         state, nxt;
  logic [HAW-1:0] beat;
  logic [3:0]     qi;
  logic           pend;
  logic           wd_exp;
  logic           h_we, y_we;
  cplx_t          wdat, h_rd, y_rd;

  assign wdat = {wr_data_r, wr_data_i};
  assign h_we = wr_en && !busy && !wr_sel && addr_ok(wr_addr, HD);
  assign y_we = wr_en && !busy && wr_sel && addr_ok(wr_addr, Y_LEN);

  cplx_sample_buf #(.DEPTH(HD)) u_hbuf (
    .clk   (clk),
    .we    (h_we),
    .waddr (wr_addr[HAW-1:0]),
    .wdata (wdat),
    .raddr (beat),
    .rdata (h_rd)
  );

  cplx_sample_buf #(.DEPTH(Y_LEN)) u_ybuf (
    .clk   (clk),
    .we    (y_we),
    .waddr (wr_addr[YAW-1:0]),
    .wdata (wdat),
    .raddr (beat[YAW-1:0]),
    .rdata (y_rd)
  );

  // next state and Moore control outputs
  always_comb begin
    nxt         = state;
    busy        = 1'b0;
    all_done    = 1'b0;
    start_new_q = 1'b0;
    H_in_valid  = 1'b0;
    Y_in_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) nxt = START;
      end
      START: begin
        busy        = 1'b1;
        start_new_q = 1'b1;
        nxt         = STREAM;
      end
      STREAM: begin
        busy       = 1'b1;
        H_in_valid = 1'b1;
        Y_in_valid = int'(beat) < Y_LEN;
        if (beat == HAW'(HD - 1)) nxt = WAIT_DONE;
      end
      WAIT_DONE: begin
        busy = 1'b1;
        if (q_done || pend)
          nxt = (qi == 4'(NUM_Q - 1)) ? FINISH : START;
        else if (wd_exp)
          nxt = IDLE;
      end
      FINISH: begin
        all_done = 1'b1;
        nxt      = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign q_index = qi;
  assign H_in_r  = H_in_valid ? h_rd.r : '0;
  assign H_in_i  = H_in_valid ? h_rd.i : '0;
  assign Y_in_r  = Y_in_valid ? y_rd.r : '0;
  assign Y_in_i  = Y_in_valid ? y_rd.i : '0;

  // state, beat counter, pass index and early-done flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      beat  <= '0;
      qi    <= '0;
      pend  <= 1'b0;
    end else begin
      state <= nxt;
      beat  <= (state == STREAM) ? beat + 1'b1 : '0;
      if (nxt == IDLE)
        qi <= '0;
      else if (state == WAIT_DONE && nxt == START)
        qi <= qi + 1'b1;
      unique case (state)
        START:   pend <= q_done;
        STREAM:  pend <= pend | q_done;
        default: pend <= 1'b0;
      endcase
    end
  end

`ifdef HY_DRV_WATCHDOG_EN
  localparam int WW = $clog2(TIMEOUT);

  logic [WW-1:0] wd;
  logic          err_q;

  // count WAIT_DONE cycles; a timeout leaves a sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      wd    <= '0;
      err_q <= 1'b0;
    end else begin
      wd <= (state == WAIT_DONE) ? wd + 1'b1 : '0;
      if (state == WAIT_DONE && nxt == IDLE) err_q <= 1'b1;
    end
  end

  assign wd_exp = wd == WW'(TIMEOUT - 1);
  assign err    = err_q;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = TIMEOUT;
  assign wd_exp         = 1'b0;
  assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_hy_stream_driver.sv
// Self-checking bench for hy_stream_driver.
// Expected outputs come from a pass-schedule model built from the timing rules.
module tb_hy_stream_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en = 1'b0;
  logic        wr_sel = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [15:0] wr_data_r = '0;
  logic [15:0] wr_data_i = '0;
  logic        go = 1'b0;
  logic        q_done = 1'b0;
  logic        busy, all_done, err, start_new_q;
  logic [3:0]  q_index;
  logic        H_in_valid, Y_in_valid;
  logic [15:0] H_in_r, H_in_i, Y_in_r, Y_in_i;

  hy_stream_driver #(.TIMEOUT(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wr_sel      (wr_sel),
    .wr_addr     (wr_addr),
    .wr_data_r   (wr_data_r),
    .wr_data_i   (wr_data_i),
    .go          (go),
    .busy        (busy),
    .all_done    (all_done),
    .err         (err),
    .start_new_q (start_new_q),
    .q_index     (q_index),
    .H_in_valid  (H_in_valid),
    .H_in_r      (H_in_r),
    .H_in_i      (H_in_i),
    .Y_in_valid  (Y_in_valid),
    .Y_in_r      (Y_in_r),
    .Y_in_i      (Y_in_i),
    .q_done      (q_done)
  );

  always #5 clk = ~clk;

  logic [73:0] act;
  assign act = {busy, all_done, err, start_new_q, q_index,
                H_in_valid, H_in_r, H_in_i,
                Y_in_valid, Y_in_r, Y_in_i};

  int ncmp = 0;
  int nfail = 0;

  logic [15:0] hr [16];
  logic [15:0] hi [16];
  logic [15:0] yr [8];
  logic [15:0] yi [8];

  typedef struct {
    bit rst; bit go; bit qd;
    bit busy; bit snq; bit hv; bit yv; int hb;
  } vec_t;

  typedef struct {
    bit sel; logic [4:0] addr; logic [15:0] r; logic [15:0] i;
  } wr_t;

  function automatic logic [73:0] idle_pk(logic er, logic ad, logic [3:0] qi);
    return {1'b0, ad, er, 1'b0, qi, 1'b0, 32'd0, 1'b0, 32'd0};
  endfunction

  function automatic logic [73:0] pass_pk(int p, int rel);
    logic hv, yv;
    logic [15:0] a, b, c, e;
    hv = rel >= 1 && rel <= 16;
    yv = rel >= 1 && rel <= 8;
    a = '0; b = '0; c = '0; e = '0;
    if (hv) begin a = hr[rel-1]; b = hi[rel-1]; end
    if (yv) begin c = yr[rel-1]; e = yi[rel-1]; end
    return {1'b1, 1'b0, 1'b0, rel == 0, 4'(p), hv, a, b, yv, c, e};
  endfunction

  task automatic chk(input string nm, input int t, input logic [73:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cycle %0d: got %h want %h", nm, t, act, exp);
    end
  endtask

  task automatic wr(input bit sel, input logic [4:0] a,
                    input logic [15:0] r, input logic [15:0] i);
    @(negedge clk);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a;
    wr_data_r = r; wr_data_i = i;
    @(negedge clk);
    wr_en = 1'b0;
    if (!sel && a < 16) begin hr[a] = r; hi[a] = i; end
    if (sel && a < 8) begin yr[a[2:0]] = r; yi[a[2:0]] = i; end
  endtask

  task automatic run(input string nm, input int d[16], input bit qhold,
                     input int abort_t, input bit noise, output int done_at);
    int st[17];
    int endt, lastb, p;
    logic [73:0] e;
    st[0] = 1;
    for (int k = 0; k < 16; k++) begin
      st[k+1] = st[k] + 18;
      if (st[k] + d[k] + 1 > st[k+1]) st[k+1] = st[k] + d[k] + 1;
    end
    lastb = (abort_t >= 0) ? abort_t : st[16];
    endt = (abort_t >= 0) ? abort_t + 1 : st[16] + 2;
    done_at = -1;
    for (int t = 0; t <= endt; t++) begin
      @(negedge clk);
      if (t == 0 || t > st[16] || (abort_t >= 0 && t > abort_t))
        e = idle_pk(1'b0, 1'b0, 4'd0);
      else if (t == st[16])
        e = idle_pk(1'b0, 1'b1, 4'd15);
      else begin
        p = 0;
        while (p < 15 && t >= st[p+1]) p++;
        e = pass_pk(p, t - st[p]);
      end
      chk(nm, t, e);
      if (all_done === 1'b1 && done_at < 0) done_at = t;
      rst = (t == abort_t);
      go = (t == 0);
      wr_en = 1'b0;
      q_done = 1'b0;
      if (qhold) q_done = t >= 1 && t < st[16];
      else
        for (int k = 0; k < 16; k++)
          if (t == st[k] + d[k]) q_done = 1'b1;
      if (noise && t >= 1 && t < lastb) begin
        if ($urandom_range(0, 3) == 0) go = 1'b1;
        if ($urandom_range(0, 2) == 0) begin
          wr_en = 1'b1;
          wr_sel = 1'($urandom_range(0, 1));
          wr_addr = 5'($urandom_range(0, 31));
          wr_data_r = 16'($urandom);
          wr_data_i = 16'($urandom);
        end
        if (t == st[2] + 5) begin
          wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 5'd3;
          wr_data_r = 16'h7fff; wr_data_i = 16'h7fff;
        end
      end
    end
    if (abort_t < 0) begin
      ncmp++;
      if (done_at != st[16]) begin
        nfail++;
        $display("FAIL %s all_done cycle: got %0d want %0d", nm, done_at, st[16]);
      end
    end
  endtask

  initial begin
    vec_t tv[10];
    wr_t  ow[4];
    int   d[16];
    int   dn;

    tv[0] = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[1] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tv[2] = '{0, 0, 0, 1, 0, 1, 1, 0};
    tv[3] = '{0, 0, 1, 1, 0, 1, 1, 1};
    tv[4] = '{1, 0, 0, 1, 0, 1, 1, 2};
    tv[5] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tv[6] = '{0, 1, 0, 0, 0, 0, 0, 0};
    tv[7] = '{0, 0, 0, 1, 1, 0, 0, 0};
    tv[8] = '{1, 0, 0, 1, 0, 1, 1, 0};
    tv[9] = '{0, 0, 0, 0, 0, 0, 0, 0};

    ow[0] = '{0, 5'd20, 16'h1234, 16'h5678};
    ow[1] = '{1, 5'd9,  16'h4321, 16'h8765};
    ow[2] = '{0, 5'd31, 16'hdead, 16'hbeef};
    ow[3] = '{1, 5'd15, 16'hcafe, 16'hf00d};

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset", 0, idle_pk(1'b0, 1'b0, 4'd0));
    rst = 1'b0;

    for (int k = 0; k < 16; k++)
      wr(1'b0, 5'(k), 16'(k << 8), 16'(-(k << 8)));
    for (int k = 0; k < 8; k++)
      wr(1'b1, 5'(k), 16'((k + 1) << 8), 16'((k + 1) << 8));
    for (int k = 0; k < 4; k++)
      wr(ow[k].sel, ow[k].addr, ow[k].r, ow[k].i);

    for (int k = 0; k < 10; k++) begin
      logic [73:0] e;
      logic [15:0] a, b, c, f;
      a = '0; b = '0; c = '0; f = '0;
      if (tv[k].hv) begin a = hr[tv[k].hb]; b = hi[tv[k].hb]; end
      if (tv[k].yv) begin c = yr[tv[k].hb]; f = yi[tv[k].hb]; end
      e = {tv[k].busy, 1'b0, 1'b0, tv[k].snq, 4'd0,
           tv[k].hv, a, b, tv[k].yv, c, f};
      @(negedge clk);
      chk("table", k, e);
      rst = tv[k].rst;
      go = tv[k].go;
      q_done = tv[k].qd;
    end
    rst = 1'b0; go = 1'b0; q_done = 1'b0;

    for (int k = 0; k < 16; k++) d[k] = 21;
    run("plan", d, 1'b0, -1, 1'b0, dn);

    for (int k = 0; k < 16; k++) d[k] = 0;
    run("qhold", d, 1'b1, -1, 1'b0, dn);
    ncmp++;
    if (dn != 289) begin
      nfail++;
      $display("FAIL qhold_done_at: got %0d want 289", dn);
    end

    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < 16; k++) d[k] = $urandom_range(0, 25);
      run("random", d, 1'b0, -1, 1'b1, dn);
    end

    for (int k = 0; k < 16; k++) d[k] = 21;
    run("abort", d, 1'b0, 1 + 5 * 22 + 3, 1'b0, dn);
    rst = 1'b0;
    run("restart", d, 1'b0, -1, 1'b0, dn);

`ifdef HY_DRV_WATCHDOG_EN
    for (int t = 0; t <= 100; t++) begin
      logic [73:0] e;
      @(negedge clk);
      if (t == 0) e = idle_pk(1'b0, 1'b0, 4'd0);
      else if (t < 82) e = pass_pk(0, t - 1);
      else e = idle_pk(1'b1, 1'b0, 4'd0);
      chk("watchdog", t, e);
      go = (t == 0);
      q_done = 1'b0;
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
